// File: rtl/light_pattern_decoder.sv
// Light pattern decoder: recovers OFF / ON / SLOW / FAST from the observed
// rear_light waveform by timing high and low runs in beat ticks.
//
// state  | meaning
// IDLE   | after reset, nothing learned yet
// STEADY | level held for STEADY_TICKS, mode is 00/01
// HALF   | one edge seen, only one half of a period measured
// BLINK  | full periods being measured, every edge reclassifies
module light_pattern_decoder #(
  parameter int CNT_W        = 8,
  parameter int STEADY_TICKS = 64,
  parameter int SLOW_MIN     = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count_en,
  input  logic             rear_light,
  output logic [1:0]       mode,
  output logic             mode_valid,
  output logic             mode_change,
  output logic [CNT_W-1:0] on_ticks,
  output logic [CNT_W-1:0] off_ticks
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEADY = 2'd1,
    HALF   = 2'd2,
    BLINK  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX  = '1;
  localparam logic [CNT_W-1:0] RUN_STDY = CNT_W'(STEADY_TICKS);
  localparam logic [CNT_W:0]   PER_SLOW = (CNT_W+1)'(SLOW_MIN);

  state_t           state, state_nxt;
  logic             sync1, sync2, level_q;
  logic             edge_seen, fall, timeout, slow;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W:0]   period;
  logic             classify;
  logic [1:0]       mode_nxt;

  assign edge_seen = sync2 ^ level_q;
  assign fall      = level_q & ~sync2;
  assign timeout   = (run_cnt == RUN_STDY);
  // The freshly ending run plus the stored opposite half gives one full period.
  assign period    = {1'b0, run_cnt} + {1'b0, (fall ? off_ticks : on_ticks)};
  assign slow      = (period >= PER_SLOW);

  // Synchronize rear_light and keep one extra copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1   <= rear_light;
      sync2   <= sync1;
      level_q <= sync2;
    end
  end

  // Run-length counter; the ending run is captured into on/off_ticks on each edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt   <= '0;
      on_ticks  <= '0;
      off_ticks <= '0;
    end else if (edge_seen) begin
      run_cnt <= count_en ? CNT_W'(1) : '0;
      if (fall) on_ticks  <= run_cnt;
      else      off_ticks <= run_cnt;
    end else if (count_en && run_cnt != RUN_MAX) begin
      run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and classification; an edge takes priority over a timeout.
  always_comb begin
    state_nxt = state;
    classify  = 1'b0;
    mode_nxt  = mode;
    case (state)
      IDLE, STEADY: begin
        if (edge_seen) begin
          state_nxt = HALF;
        end else if (state == IDLE && timeout) begin
          state_nxt = STEADY;
          classify  = 1'b1;
          mode_nxt  = {1'b0, sync2};
        end
      end
      HALF, BLINK: begin
        if (edge_seen) begin
          state_nxt = BLINK;
          classify  = 1'b1;
          mode_nxt  = slow ? 2'b10 : 2'b11;
        end else if (timeout) begin
          state_nxt = STEADY;
          classify  = 1'b1;
          mode_nxt  = {1'b0, sync2};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mode outputs; mode_change only when the visible result actually changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode        <= 2'b00;
      mode_valid  <= 1'b0;
      mode_change <= 1'b0;
    end else if (classify) begin
      mode        <= mode_nxt;
      mode_valid  <= 1'b1;
      mode_change <= ({1'b1, mode_nxt} != {mode_valid, mode});
    end else begin
      mode_change <= 1'b0;
    end
  end

endmodule
